// File: rtl/dev_pkg.sv
// Shared definitions for the keyboard/screen device driver: CSR bit
// positions, register addresses and the CSR type.
package dev_pkg;

  localparam int CSR_IE  = 4;
  localparam int CSR_OF  = 3;
  localparam int CSR_DBA = 2;
  localparam int CSR_IO  = 1;

  localparam logic [1:0] ADDR_KB_CSR  = 2'd0;
  localparam logic [1:0] ADDR_KB_DR   = 2'd1;
  localparam logic [1:0] ADDR_SCR_CSR = 2'd2;
  localparam logic [1:0] ADDR_SCR_DR  = 2'd3;

  typedef logic [7:0] csr_t;

  // Assemble a CSR image; unlisted bits read as 0.
  function automatic csr_t make_csr(input logic ie, input logic of,
                                    input logic dba, input logic io);
    csr_t c;
    c          = '0;
    c[CSR_IE]  = ie;
    c[CSR_OF]  = of;
    c[CSR_DBA] = dba;
    c[CSR_IO]  = io;
    return c;
  endfunction

endpackage

// File: rtl/dev_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. dout shows the head entry
// and reads as 0 while empty. A push on a full FIFO is accepted only when
// a pop happens in the same cycle. DEPTH must be a power of 2.
module dev_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; the head is read before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kb_scr_fifo_drv.sv
// Buffered keyboard/screen device driver with XM-23-style CSR/DR registers.
// Keyboard bytes queue in an RX FIFO; screen bytes queue in a TX queue that
// drains over scr_valid/scr_ready.
// Optional feature macro: KB_SCR_TX_FIFO_EN selects a TX_DEPTH-entry screen
// FIFO; without it the screen queue is a single holding register.
//
// Screen handshake: scr_valid is high whenever the screen queue holds a
// byte; scr_data is the head and stays stable until transferred; a byte
// transfers on every rising edge where scr_valid && scr_ready are both high.
module kb_scr_fifo_drv
  import dev_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        bus_addr,
  input  logic              bus_rd,
  input  logic              bus_wr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              kb_strobe,
  input  logic [DATA_W-1:0] kb_data,
  output logic              scr_valid,
  output logic [DATA_W-1:0] scr_data,
  input  logic              scr_ready,
  output logic              irq_kb,
  output logic              irq_scr
);

  logic rd_kb_dr, wr_kb_csr, wr_scr_csr, wr_scr_dr;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic kb_of_set, scr_of_set;
  logic kb_ie, kb_of, scr_ie, scr_of;
  logic [DATA_W-1:0] rx_dout, tx_dout, scr_last;
  logic [$clog2(RX_DEPTH):0] rx_count;
  csr_t kb_csr, scr_csr;
  logic unused_ok;

  assign rd_kb_dr   = bus_rd && (bus_addr == ADDR_KB_DR);
  assign wr_kb_csr  = bus_wr && (bus_addr == ADDR_KB_CSR);
  assign wr_scr_csr = bus_wr && (bus_addr == ADDR_SCR_CSR);
  assign wr_scr_dr  = bus_wr && (bus_addr == ADDR_SCR_DR);

  // Keyboard side: a pop frees the slot a same-cycle strobe lands in.
  assign rx_pop    = rd_kb_dr && !rx_empty;
  assign rx_push   = kb_strobe && (!rx_full || rx_pop);
  assign kb_of_set = kb_strobe && rx_full && !rx_pop;

  dev_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (kb_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Screen side: same full/pop rule as the keyboard queue.
  assign tx_pop     = scr_valid && scr_ready;
  assign tx_push    = wr_scr_dr && (!tx_full || tx_pop);
  assign scr_of_set = wr_scr_dr && tx_full && !tx_pop;

`ifdef KB_SCR_TX_FIFO_EN
  logic [$clog2(TX_DEPTH):0] tx_count;

  dev_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus_wdata),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign unused_ok = ^{rx_count, tx_count};
`else
  logic hold_v;

  // Single holding register; refilled in the same cycle it is drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v  <= 1'b0;
      tx_dout <= '0;
    end else if (tx_push) begin
      hold_v  <= 1'b1;
      tx_dout <= bus_wdata;
    end else if (tx_pop) begin
      hold_v  <= 1'b0;
    end
  end

  assign tx_full   = hold_v;
  assign tx_empty  = !hold_v;
  assign unused_ok = ^{rx_count, 32'(TX_DEPTH)};
`endif

  assign scr_valid = !tx_empty;
  assign scr_data  = tx_dout;

  // CSR state: IE is plain read/write; OF sets on a dropped byte and
  // clears on a 0 write, with the set taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_ie  <= 1'b0;
      kb_of  <= 1'b0;
      scr_ie <= 1'b0;
      scr_of <= 1'b0;
    end else begin
      if (wr_kb_csr)  kb_ie  <= bus_wdata[CSR_IE];
      if (wr_scr_csr) scr_ie <= bus_wdata[CSR_IE];
      if (kb_of_set)                             kb_of <= 1'b1;
      else if (wr_kb_csr && !bus_wdata[CSR_OF])  kb_of <= 1'b0;
      if (scr_of_set)                            scr_of <= 1'b1;
      else if (wr_scr_csr && !bus_wdata[CSR_OF]) scr_of <= 1'b0;
    end
  end

  // Last byte written to the screen DR, returned by DR reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         scr_last <= '0;
    else if (wr_scr_dr) scr_last <= bus_wdata;
  end

  assign kb_csr  = make_csr(kb_ie,  kb_of,  !rx_empty, 1'b1);
  assign scr_csr = make_csr(scr_ie, scr_of, !tx_full,  1'b0);

  // Registered read mux; the value holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata <= '0;
    end else if (bus_rd) begin
      case (bus_addr)
        ADDR_KB_CSR:  bus_rdata <= DATA_W'(kb_csr);
        ADDR_KB_DR:   bus_rdata <= rx_dout;
        ADDR_SCR_CSR: bus_rdata <= DATA_W'(scr_csr);
        default:      bus_rdata <= scr_last;
      endcase
    end
  end

  assign irq_kb  = kb_ie  && !rx_empty;
  assign irq_scr = scr_ie && !tx_full;

endmodule

// File: tb/tb_kb_scr_fifo_drv.sv
// Directed bench for kb_scr_fifo_drv (default parameters). Inputs change
// and outputs are sampled on the falling clock edge.
module tb_kb_scr_fifo_drv;
  import dev_pkg::*;

  localparam int DATA_W   = 8;
  localparam int RX_DEPTH = 8;
  localparam int TX_DEPTH = 4;
`ifdef KB_SCR_TX_FIFO_EN
  localparam int SCR_N = TX_DEPTH;
`else
  localparam int SCR_N = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        bus_addr = 2'd0;
  logic              bus_rd = 1'b0;
  logic              bus_wr = 1'b0;
  logic [DATA_W-1:0] bus_wdata = '0;
  logic [DATA_W-1:0] bus_rdata;
  logic              kb_strobe = 1'b0;
  logic [DATA_W-1:0] kb_data = '0;
  logic              scr_valid;
  logic [DATA_W-1:0] scr_data;
  logic              scr_ready = 1'b0;
  logic              irq_kb;
  logic              irq_scr;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  kb_scr_fifo_drv #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .kb_strobe (kb_strobe),
    .kb_data   (kb_data),
    .scr_valid (scr_valid),
    .scr_data  (scr_data),
    .scr_ready (scr_ready),
    .irq_kb    (irq_kb),
    .irq_scr   (irq_scr)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic bus_read(input logic [1:0] a, output logic [DATA_W-1:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic kb_pulse(input logic [DATA_W-1:0] d);
    @(negedge clk);
    kb_data   = d;
    kb_strobe = 1'b1;
    @(negedge clk);
    kb_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({irq_kb, irq_scr, scr_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got irq_kb/irq_scr/valid=%b expected 000", {irq_kb, irq_scr, scr_valid});
    end
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL reset_kb_csr got %h expected 02", d); end
    bus_read(ADDR_KB_DR, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_kb_dr got %h expected 00", d); end
    bus_read(ADDR_SCR_CSR, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL reset_scr_csr got %h expected 04", d); end
    bus_read(ADDR_SCR_DR, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_scr_dr got %h expected 00", d); end
  endtask

  task automatic test_kb_irq();
    logic [DATA_W-1:0] d;
    bus_write(ADDR_KB_CSR, 8'h10);
    kb_pulse(8'h61);
    checks++; if (irq_kb !== 1'b1) begin errors++; $display("FAIL kb_irq_set got %b expected 1", irq_kb); end
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h16) begin errors++; $display("FAIL kb_csr_ie_dba got %h expected 16", d); end
    bus_read(ADDR_KB_DR, d);
    checks++; if (d !== 8'h61) begin errors++; $display("FAIL kb_dr_first got %h expected 61", d); end
    checks++; if (irq_kb !== 1'b0) begin errors++; $display("FAIL kb_irq_clear got %b expected 0", irq_kb); end
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL kb_csr_after_pop got %h expected 12", d); end
  endtask

  task automatic test_kb_overrun();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] e;
    bus_write(ADDR_KB_CSR, 8'h00);
    for (int i = 0; i <= RX_DEPTH; i++) begin
      kb_pulse(DATA_W'(8'h41 + i));
      if (i < RX_DEPTH) exp_q.push_back(DATA_W'(8'h41 + i));
    end
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h0E) begin errors++; $display("FAIL kb_overrun_csr got %h expected 0e", d); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus_read(ADDR_KB_DR, d);
      checks++; if (d !== e) begin errors++; $display("FAIL kb_overrun_order got %h expected %h", d, e); end
    end
    bus_read(ADDR_KB_DR, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL kb_dr_empty got %h expected 00", d); end
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h0A) begin errors++; $display("FAIL kb_of_sticky got %h expected 0a", d); end
    bus_write(ADDR_KB_CSR, 8'h08);
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h0A) begin errors++; $display("FAIL kb_of_write1 got %h expected 0a", d); end
    bus_write(ADDR_KB_CSR, 8'h00);
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL kb_of_clear got %h expected 02", d); end
  endtask

  task automatic test_rx_full_push_pop();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < RX_DEPTH; i++) begin
      kb_pulse(DATA_W'(8'h50 + i));
      exp_q.push_back(DATA_W'(8'h50 + i));
    end
    @(negedge clk);
    kb_data = 8'h7A; kb_strobe = 1'b1;
    bus_addr = ADDR_KB_DR; bus_rd = 1'b1;
    @(negedge clk);
    kb_strobe = 1'b0; bus_rd = 1'b0;
    exp_q.push_back(8'h7A);
    e = exp_q.pop_front();
    checks++; if (bus_rdata !== e) begin errors++; $display("FAIL full_push_pop_read got %h expected %h", bus_rdata, e); end
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL full_push_pop_no_of got %h expected 06", d); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus_read(ADDR_KB_DR, d);
      checks++; if (d !== e) begin errors++; $display("FAIL full_push_pop_order got %h expected %h", d, e); end
    end
    // Push into an empty FIFO while reading DR: read sees 0, push lands.
    @(negedge clk);
    kb_data = 8'h5C; kb_strobe = 1'b1;
    bus_addr = ADDR_KB_DR; bus_rd = 1'b1;
    @(negedge clk);
    kb_strobe = 1'b0; bus_rd = 1'b0;
    checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL empty_push_read got %h expected 00", bus_rdata); end
    bus_read(ADDR_KB_DR, d);
    checks++; if (d !== 8'h5C) begin errors++; $display("FAIL empty_push_lands got %h expected 5c", d); end
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL rx_drained_csr got %h expected 02", d); end
  endtask

  task automatic test_scr_queue();
    logic [DATA_W-1:0] d;
    scr_ready = 1'b0;
    for (int i = 0; i < SCR_N; i++) begin
      bus_write(ADDR_SCR_DR, DATA_W'(8'h30 + i));
      if (i == 0) begin
        checks++;
        if (scr_valid !== 1'b1 || scr_data !== 8'h30) begin
          errors++; $display("FAIL scr_first_valid got valid=%b data=%h expected 1/30", scr_valid, scr_data);
        end
      end
    end
    bus_read(ADDR_SCR_CSR, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL scr_full_dba got %h expected 00", d); end
    bus_write(ADDR_SCR_DR, DATA_W'(8'h30 + SCR_N));
    bus_read(ADDR_SCR_CSR, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL scr_overrun got %h expected 08", d); end
    bus_read(ADDR_SCR_DR, d);
    checks++; if (d !== DATA_W'(8'h30 + SCR_N)) begin errors++; $display("FAIL scr_dr_last got %h expected %h", d, 8'h30 + SCR_N); end
    checks++; if (scr_data !== 8'h30) begin errors++; $display("FAIL scr_data_stable got %h expected 30", scr_data); end
    for (int i = 0; i < SCR_N; i++) begin
      @(negedge clk);
      scr_ready = 1'b1;
      checks++;
      if (scr_valid !== 1'b1 || scr_data !== DATA_W'(8'h30 + i)) begin
        errors++; $display("FAIL scr_drain got valid=%b data=%h expected 1/%h", scr_valid, scr_data, 8'h30 + i);
      end
    end
    @(negedge clk);
    checks++; if (scr_valid !== 1'b0) begin errors++; $display("FAIL scr_drained got %b expected 0", scr_valid); end
    scr_ready = 1'b0;
    bus_read(ADDR_SCR_CSR, d);
    checks++; if (d !== 8'h0C) begin errors++; $display("FAIL scr_csr_drained got %h expected 0c", d); end
    bus_write(ADDR_SCR_CSR, 8'h10);
    checks++; if (irq_scr !== 1'b1) begin errors++; $display("FAIL scr_irq_set got %b expected 1", irq_scr); end
    bus_read(ADDR_SCR_CSR, d);
    checks++; if (d !== 8'h14) begin errors++; $display("FAIL scr_csr_ie got %h expected 14", d); end
    bus_write(ADDR_SCR_CSR, 8'h00);
    checks++; if (irq_scr !== 1'b0) begin errors++; $display("FAIL scr_irq_clear got %b expected 0", irq_scr); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    @(negedge clk);
    scr_ready = 1'b1;
    bus_addr = ADDR_SCR_DR; bus_wdata = 8'hA0; bus_wr = 1'b1;
    @(negedge clk);
    bus_wdata = 8'hA1;
    checks++;
    if (scr_valid !== 1'b1 || scr_data !== 8'hA0) begin
      errors++; $display("FAIL b2b_first got valid=%b data=%h expected 1/a0", scr_valid, scr_data);
    end
    @(negedge clk);
    bus_wr = 1'b0;
    checks++;
    if (scr_valid !== 1'b1 || scr_data !== 8'hA1) begin
      errors++; $display("FAIL b2b_second got valid=%b data=%h expected 1/a1", scr_valid, scr_data);
    end
    @(negedge clk);
    checks++; if (scr_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b expected 0", scr_valid); end
    scr_ready = 1'b0;
    bus_read(ADDR_SCR_CSR, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL b2b_no_of got %h expected 04", d); end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] d;
    scr_ready = 1'b0;
    bus_write(ADDR_KB_CSR, 8'h10);
    bus_write(ADDR_SCR_CSR, 8'h10);
    bus_write(ADDR_SCR_DR, 8'h30);
    kb_pulse(8'h11);
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h16) begin errors++; $display("FAIL pre_reset_kb_csr got %h expected 16", d); end
    @(negedge clk);
    scr_ready = 1'b1;
    checks++; if (scr_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b expected 1", scr_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({scr_valid, irq_kb, irq_scr} !== 3'b000 || scr_data !== 8'h00 || bus_rdata !== 8'h00) begin
      errors++; $display("FAIL async_reset got valid/irq_kb/irq_scr=%b data=%h rdata=%h expected 000/00/00",
                         {scr_valid, irq_kb, irq_scr}, scr_data, bus_rdata);
    end
    scr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(ADDR_KB_CSR, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL post_reset_kb_csr got %h expected 02", d); end
    bus_read(ADDR_SCR_CSR, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL post_reset_scr_csr got %h expected 04", d); end
    bus_read(ADDR_KB_DR, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_kb_dr got %h expected 00", d); end
  endtask

  initial begin
    test_reset();
    test_kb_irq();
    test_kb_overrun();
    test_rx_full_push_pop();
    test_scr_queue();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
